simon: RTL and testbench
========================

SIMON -- requirements
Module: simon

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: pclk (clock) and rst (reset).
REQ-002 Ports SHALL be:
- pclk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous active-low reset.
- level  in  1  difficulty: 0 easy, 1 hard; sampled live, not latched.
- pattern  in  4  player switch value.
- pattern_leds  out  4  pattern display.
- mode_leds  out  3  current mode indicator.
REQ-003 Parameters SHALL be: MEM_DEPTH, default 64, maximum sequence length; PAT_W, default 4, pattern width.

Function
REQ-004 The block SHALL hold a sequence memory of MEM_DEPTH x PAT_W, a 7-bit sequence length count (0..64), and a 6-bit index idx.
REQ-005 It SHALL implement four modes with these mode_leds encodings: INPUT=001, PLAYBACK=010, REPEAT=100, DONE=111.
REQ-006 Outputs SHALL be combinational from the current state, memory, and pattern, with no output register.
REQ-007 pattern_leds SHALL be:
- INPUT and REPEAT: equal to pattern.
- PLAYBACK and DONE: equal to mem[idx].
REQ-008 A pattern SHALL be valid when level=0, or when level=1 and exactly one bit of pattern is set. The level value present at the clock edge applies.
REQ-009 INPUT, each rising edge:
- pattern valid and count<64: write mem[count]=pattern, count+=1, idx=0, go to PLAYBACK.
- otherwise: stay in INPUT with no state change.
REQ-010 PLAYBACK, each rising edge:
- idx==count-1: idx=0, go to REPEAT.
- otherwise: idx+=1 and stay in PLAYBACK.
REQ-011 REPEAT, each rising edge, pattern is compared with mem[idx]:
- mismatch: idx=0, go to DONE.
- match and idx==count-1: idx=0, go to INPUT.
- match otherwise: idx+=1 and stay in REPEAT.
REQ-012 DONE, each rising edge: idx wraps to 0 when idx==count-1, otherwise idx+=1. DONE SHALL be exited only by reset.
REQ-013 When count==64, INPUT SHALL reject every pattern and the game SHALL remain in INPUT.
REQ-014 Writes SHALL occur only in INPUT on acceptance; the memory SHALL be read-only in every other mode.

Reset
REQ-015 When rst==0 at a rising edge, the block SHALL enter INPUT with count=0 and idx=0, from any mode. Memory contents SHALL be left unchanged.
REQ-016 After reset, mode_leds SHALL be 001 and pattern_leds SHALL follow pattern.
REQ-017 Reset SHALL take priority over all other behaviour.

Verification
REQ-018 The bench SHALL cover these scenarios:
- Reset, then level=0, pattern=0001, one clock: mode_leds=010 and pattern_leds=0001 with pattern=0000. One more clock: mode_leds=100.
- In REPEAT with pattern=0001, one clock: mode_leds=001.
- level=1, pattern=1010, one clock: mode_leds stays 001. Then pattern=1000, one clock: mode_leds=010, pattern_leds=0001. Next clock: pattern_leds=1000. Next clock: mode_leds=100.
- REPEAT with stored sequence {0001,1000}: guess 0001 gives mode_leds=100; then guess 0100 gives mode_leds=111 and pattern_leds=0001. Successive clocks give 1000, then 0001 (wrap), and mode_leds stays 111.
- Input 64 valid patterns, each with a correct repeat: the 65th input is rejected and the game remains in INPUT.
- rst=0 asserted while in PLAYBACK, REPEAT, or DONE: the next edge gives mode_leds=001, and a new single-entry game plays back the new pattern.

Source files
------------

// File: rtl/simon.sv
// Simon memory game: stores a growing sequence of player patterns, plays it
// back on the LEDs, then checks the player's repeat of the whole sequence.
module simon #(
    parameter int unsigned MEM_DEPTH = 64,
    parameter int unsigned PAT_W     = 4
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             level,
    input  logic [PAT_W-1:0] pattern,
    output logic [PAT_W-1:0] pattern_leds,
    output logic [2:0]       mode_leds
);

    localparam int unsigned CNT_W = $clog2(MEM_DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

    // State encodings double as the mode LED patterns.
    typedef enum logic [2:0] {
        S_INPUT    = 3'b001,
        S_PLAYBACK = 3'b010,
        S_REPEAT   = 3'b100,
        S_DONE     = 3'b111
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] idx;
    logic [PAT_W-1:0] mem [MEM_DEPTH];

    logic             valid;
    logic             full;
    logic             last;
    logic [PAT_W-1:0] stored;

    always_comb begin
        valid  = !level || $onehot(pattern);
        full   = (count == CNT_W'(MEM_DEPTH));
        last   = (CNT_W'(idx) == (count - CNT_W'(1)));
        stored = mem[idx];
    end

    // Sequence memory: written only when INPUT accepts a pattern; untouched by reset.
    always_ff @(posedge pclk) begin
        if (rst && (state == S_INPUT) && valid && !full) begin
            mem[count[IDX_W-1:0]] <= pattern;
        end
    end

    // Game state machine.
    always_ff @(posedge pclk) begin
        if (!rst) begin
            state <= S_INPUT;
            count <= '0;
            idx   <= '0;
        end else begin
            case (state)
                S_INPUT: begin
                    if (valid && !full) begin
                        count <= count + CNT_W'(1);
                        idx   <= '0;
                        state <= S_PLAYBACK;
                    end
                end
                S_PLAYBACK: begin
                    if (last) begin
                        idx   <= '0;
                        state <= S_REPEAT;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                S_REPEAT: begin
                    if (pattern != stored) begin
                        idx   <= '0;
                        state <= S_DONE;
                    end else if (last) begin
                        idx   <= '0;
                        state <= S_INPUT;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    // Keeps cycling the stored sequence until reset.
                    if (last) begin
                        idx <= '0;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: begin
                    state <= S_INPUT;
                    count <= '0;
                    idx   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        mode_leds = state;
        if ((state == S_INPUT) || (state == S_REPEAT)) begin
            pattern_leds = pattern;
        end else begin
            pattern_leds = stored;
        end
    end

endmodule

// File: tb/tb_simon.sv
// Scoreboard bench for simon: stimulus queues expected LED values, a monitor
// pops and compares them at the sampling points.
module tb_simon;

    logic       pclk;
    logic       rst;
    logic       level;
    logic [3:0] pattern;
    logic [3:0] pattern_leds;
    logic [2:0] mode_leds;

    simon #(.MEM_DEPTH(64), .PAT_W(4)) dut (
        .pclk        (pclk),
        .rst         (rst),
        .level       (level),
        .pattern     (pattern),
        .pattern_leds(pattern_leds),
        .mode_leds   (mode_leds)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    localparam logic [2:0] M_IN = 3'b001;
    localparam logic [2:0] M_PB = 3'b010;
    localparam logic [2:0] M_RP = 3'b100;
    localparam logic [2:0] M_DN = 3'b111;

    typedef struct {
        logic [2:0] m;
        logic [3:0] l;
        string      nm;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    event sample_ev;
    logic [3:0] seq [64];

    // Monitor: compare every pending expectation at each sampling point.
    always begin
        @(negedge pclk or sample_ev);
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (mode_leds !== e.m || pattern_leds !== e.l) begin
                bad++;
                $display("FAIL %s: mode_leds=%b pattern_leds=%b expected mode_leds=%b pattern_leds=%b",
                         e.nm, mode_leds, pattern_leds, e.m, e.l);
            end
        end
    end

    // One clock edge with the given inputs; expectation sampled at the following negedge.
    task automatic step(input logic r, input logic lv, input logic [3:0] p,
                        input logic [2:0] em, input logic [3:0] el, input string nm);
        rst = r; level = lv; pattern = p;
        @(posedge pclk);
        exp_q.push_back('{em, el, nm});
        @(negedge pclk);
        #1;
    endtask

    // Change pattern mid-cycle and check outputs without a clock edge.
    task automatic probe(input logic [3:0] p, input logic [2:0] em,
                         input logic [3:0] el, input string nm);
        pattern = p;
        #1;
        exp_q.push_back('{em, el, nm});
        ->sample_ev;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; level = 1'b0; pattern = 4'b0000;
        @(negedge pclk); #1;

        step(1'b0, 1'b0, 4'b0101, M_IN, 4'b0101, "reset");

        // Easy level, single entry game.
        step(1'b1, 1'b0, 4'b0001, M_PB, 4'b0001, "s1_playback");
        probe(4'b0000, M_PB, 4'b0001, "s1_playback_ignores_pattern");
        step(1'b1, 1'b0, 4'b0000, M_RP, 4'b0000, "s1_repeat");
        step(1'b1, 1'b0, 4'b0001, M_IN, 4'b0001, "s2_repeat_ok");

        // Hard level: non-one-hot rejected, then second entry.
        step(1'b1, 1'b1, 4'b1010, M_IN, 4'b1010, "s3_hard_reject");
        step(1'b1, 1'b1, 4'b1000, M_PB, 4'b0001, "s3_pb0");
        step(1'b1, 1'b1, 4'b0000, M_PB, 4'b1000, "s3_pb1");
        step(1'b1, 1'b1, 4'b0001, M_RP, 4'b0001, "s3_repeat");

        // Wrong guess leads to DONE, which cycles the sequence.
        step(1'b1, 1'b0, 4'b0001, M_RP, 4'b0001, "s4_guess0_ok");
        step(1'b1, 1'b0, 4'b0100, M_DN, 4'b0001, "s4_mismatch");
        step(1'b1, 1'b0, 4'b0000, M_DN, 4'b1000, "s4_done_idx1");
        step(1'b1, 1'b0, 4'b0000, M_DN, 4'b0001, "s4_done_wrap");
        step(1'b1, 1'b1, 4'b0010, M_DN, 4'b1000, "s4_done_stays");

        // Fill the memory to 64 entries with correct repeats each round.
        step(1'b0, 1'b0, 4'b0000, M_IN, 4'b0000, "s5_reset");
        for (int k = 0; k < 64; k++) begin
            seq[k] = 4'(k * 7 + 3);
            step(1'b1, 1'b0, seq[k], M_PB, seq[0], $sformatf("s5_input%0d", k));
            for (int i = 1; i <= k; i++)
                step(1'b1, 1'b0, 4'b0000, M_PB, seq[i], $sformatf("s5_pb%0d_%0d", k, i));
            step(1'b1, 1'b0, 4'b1111, M_RP, 4'b1111, $sformatf("s5_torepeat%0d", k));
            for (int i = 0; i < k; i++)
                step(1'b1, 1'b0, seq[i], M_RP, seq[i], $sformatf("s5_rep%0d_%0d", k, i));
            step(1'b1, 1'b0, seq[k], M_IN, seq[k], $sformatf("s5_repdone%0d", k));
        end
        step(1'b1, 1'b0, 4'b0110, M_IN, 4'b0110, "s5_full_reject");
        step(1'b1, 1'b1, 4'b0100, M_IN, 4'b0100, "s5_full_reject_hard");

        // Reset from PLAYBACK.
        step(1'b0, 1'b0, 4'b0000, M_IN, 4'b0000, "s6_reset0");
        step(1'b1, 1'b0, 4'b0011, M_PB, 4'b0011, "s6_pb_a");
        step(1'b0, 1'b0, 4'b1001, M_IN, 4'b1001, "s6_reset_in_pb");
        step(1'b1, 1'b0, 4'b0110, M_PB, 4'b0110, "s6_new_game_pb");
        step(1'b1, 1'b0, 4'b0000, M_RP, 4'b0000, "s6_repeat");
        // Reset from REPEAT.
        step(1'b0, 1'b0, 4'b0101, M_IN, 4'b0101, "s6_reset_in_rp");
        step(1'b1, 1'b0, 4'b1100, M_PB, 4'b1100, "s6_pb_b");
        step(1'b1, 1'b0, 4'b0000, M_RP, 4'b0000, "s6_repeat_b");
        step(1'b1, 1'b0, 4'b0000, M_DN, 4'b1100, "s6_done");
        // Reset from DONE.
        step(1'b0, 1'b0, 4'b0111, M_IN, 4'b0111, "s6_reset_in_dn");
        step(1'b1, 1'b1, 4'b0010, M_PB, 4'b0010, "s6_pb_c");

        @(negedge pclk); #1;
        if (exp_q.size() != 0) begin
            bad++;
            total++;
            $display("FAIL drain: pending=%0d expected pending=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
